route_sched: RTL

ROUTE_SCHED -- requirements
Module: route_sched

---
 rtl/route_sched.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/route_sched.sv
// Route scheduler: queues host destination IDs and sequences each leg
// (issue go command, launch, transit, dwell) toward the motion controller.
module route_sched #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DWELL = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                cmd_in,
    input  logic                      cmd_in_rdy,
    output logic                      clr_cmd_in_rdy,
    output logic [7:0]                cmd,
    output logic                      cmd_rdy,
    input  logic                      clr_cmd_rdy,
    input  logic                      in_transit,
    output logic [$clog2(DEPTH):0]    q_cnt,
    output logic                      busy,
    output logic                      leg_done,
    output logic                      overflow
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CNTW = AW + 1;
    localparam int unsigned CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNTW-1:0] FULL      = CNTW'(DEPTH);
    localparam logic [CW-1:0]   DWELL_TOP = CW'(DWELL - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_LAUNCH, S_TRANSIT, S_DWELL, S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic            run_q, run_d;
    logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNTW-1:0] q_cnt_q, q_cnt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [5:0]      mem_q [DEPTH];
    logic [5:0]      mem_d [DEPTH];
    logic [7:0]      cmd_q, cmd_d;
    logic            cmd_rdy_q, cmd_rdy_d;
    logic            clr_q, clr_d;
    logic            busy_q, busy_d;
    logic            leg_done_q, leg_done_d;
    logic            overflow_q, overflow_d;

    logic take, op_enq, op_run, op_flush, op_stop, pop, enq_ok;

    // A host command is taken only when the previous acknowledge is not still up.
    assign take     = cmd_in_rdy && !clr_q;
    assign op_enq   = take && (cmd_in[7:6] == 2'b10);
    assign op_run   = take && (cmd_in[7:6] == 2'b01);
    assign op_flush = take && (cmd_in[7:6] == 2'b11);
    assign op_stop  = take && (cmd_in[7:6] == 2'b00);
    assign pop      = (state_q == S_ISSUE) && clr_cmd_rdy && !op_stop && !op_flush
                      && (q_cnt_q != '0);
    assign enq_ok   = op_enq && ((q_cnt_q < FULL) || pop);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q      <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            q_cnt_q    <= '0;
            cnt_q      <= '0;
            cmd_q      <= 8'h00;
            cmd_rdy_q  <= 1'b0;
            clr_q      <= 1'b0;
            busy_q     <= 1'b0;
            leg_done_q <= 1'b0;
            overflow_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            run_q      <= run_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            q_cnt_q    <= q_cnt_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            cmd_rdy_q  <= cmd_rdy_d;
            clr_q      <= clr_d;
            busy_q     <= busy_d;
            leg_done_q <= leg_done_d;
            overflow_q <= overflow_d;
            mem_q      <= mem_d;
        end
    end

    // Destination queue and run flag; flush (or stop) overrides push/pop.
    always_comb begin
        run_d   = run_q;
        head_d  = head_q;
        tail_d  = tail_q;
        q_cnt_d = q_cnt_q;
        mem_d   = mem_q;
        if (op_run)  run_d = 1'b1;
        if (op_stop) run_d = 1'b0;
        if (op_flush || op_stop) begin
            head_d  = '0;
            tail_d  = '0;
            q_cnt_d = '0;
        end else begin
            if (enq_ok) begin
                mem_d[tail_q] = cmd_in[5:0];
                tail_d        = tail_q + 1'b1;
            end
            if (pop) head_d = head_q + 1'b1;
            case ({enq_ok, pop})
                2'b10:   q_cnt_d = q_cnt_q + 1'b1;
                2'b01:   q_cnt_d = q_cnt_q - 1'b1;
                default: q_cnt_d = q_cnt_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (op_stop) begin
            state_d = S_STOP;
        end else begin
            case (state_q)
                S_IDLE:    if (run_q && (q_cnt_q != '0) && !op_flush) state_d = S_ISSUE;
                S_ISSUE:   if (clr_cmd_rdy) state_d = S_LAUNCH;
                S_LAUNCH:  if (in_transit) state_d = S_TRANSIT;
                S_TRANSIT: if (!in_transit) begin
                    state_d = S_DWELL;
                    cnt_d   = DWELL_TOP;
                end
                S_DWELL:   if (cnt_q == '0) state_d = S_IDLE;
                           else cnt_d = cnt_q - 1'b1;
                S_STOP:    if (clr_cmd_rdy) state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // Registered outputs track the next state so they align with state_q.
    always_comb begin
        cmd_d      = cmd_q;
        cmd_rdy_d  = 1'b0;
        if (state_d == S_ISSUE) begin
            cmd_rdy_d = 1'b1;
            if (state_q != S_ISSUE) cmd_d = {2'b01, mem_q[head_q]};
        end else if (state_d == S_STOP) begin
            cmd_rdy_d = 1'b1;
            cmd_d     = 8'h00;
        end
        busy_d     = (state_d != S_IDLE);
        leg_done_d = (state_d == S_DWELL) && (cnt_d == '0);
        overflow_d = op_enq && !enq_ok;
        clr_d      = take;
    end

    assign clr_cmd_in_rdy = clr_q;
    assign cmd            = cmd_q;
    assign cmd_rdy        = cmd_rdy_q;
    assign q_cnt          = q_cnt_q;
    assign busy           = busy_q;
    assign leg_done       = leg_done_q;
    assign overflow       = overflow_q;

endmodule
